// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between fetch and data streams, data first; MEMORY_ARBITER_FAIR_EN adds a fetch-starvation bound
module memory_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
    state_t r_state;
    logic   w_dreq, w_igrant, w_dgrant, w_force;
    assign w_dreq    = dREN | dWEN;
    assign w_igrant  = r_state == IGRANT && iREN;
    assign w_dgrant  = r_state == DGRANT && w_dreq;
    assign ihit      = w_igrant && ram_ready;
    assign dhit      = w_dgrant && ram_ready;
    assign iload     = ihit ? ram_load : '0;
    assign dload     = dhit ? ram_load : '0;
    assign ram_ren   = w_igrant || (r_state == DGRANT && dREN);
    assign ram_wen   = r_state == DGRANT && dWEN;
    assign ram_addr  = r_state == IGRANT ? iaddr : r_state == DGRANT ? daddr : '0;
    assign ram_store = r_state == DGRANT ? dstore : '0;
`ifdef MEMORY_ARBITER_FAIR_EN
    logic [3:0] r_dstreak;
    assign w_force = iREN && r_dstreak >= 4'(MAX_DSTREAK);
    // consecutive data completions, saturating; any fetch completion clears it
    always_ff @(posedge CLK)
        if (RST) r_dstreak <= '0;
        else if (ihit) r_dstreak <= '0;
        else if (dhit && r_dstreak != 4'd15) r_dstreak <= r_dstreak + 4'd1;
`else
    assign w_force = 1'b0;
`endif
    // grant from IDLE, release on completion or on a withdrawn request
    always_ff @(posedge CLK)
        if (RST) r_state <= IDLE;
        else
            case (r_state)
                IDLE:    r_state <= (w_dreq && !w_force) ? DGRANT : iREN ? IGRANT : IDLE;
                IGRANT:  if (!iREN || ram_ready) r_state <= IDLE;
                DGRANT:  if (!w_dreq || ram_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_memory_arbiter;
    localparam int AW = 32, DW = 32, MAXD = 4;
`ifdef MEMORY_ARBITER_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    logic CLK = 0, RST = 1, iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0;
    logic [AW-1:0] iaddr = 0, daddr = 0, ram_addr;
    logic [DW-1:0] dstore = 0, ram_load = 0, iload, dload, ram_store;
    logic ihit, dhit, ram_ren, ram_wen;
    logic [131:0] all_out;
    int n_tests = 0, n_fail = 0;
    assign all_out = {ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store};

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
        .dload(dload), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        tick();
        tick();
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        tick();
        RST = 0; dWEN = 1; daddr = 32'h200; dstore = 32'h1234;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        n_tests++;
        if (ram_wen !== 1'b1 || dhit !== 1'b0) begin n_fail++; $display("FAIL reset_pre_grant: wen=%b dhit=%b expected wen=1 dhit=0", ram_wen, dhit); end
        RST = 1;
        tick();
        RST = 0; dWEN = 0;
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_mid_grant: got %h expected 0", all_out); end
        tick();
        ram_ready = 1;
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_idle_after: got %h expected 0", all_out); end
        ram_ready = 0;
    endtask

    task automatic test_lone_fetch();
        int ren_n = 0, ihit_n = 0, dhit_n = 0, hit_k = -1;
        logic [DW-1:0] got = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            iREN = k <= 3; iaddr = 32'h40; ram_ready = k == 3;
            ram_load = (k == 3) ? 32'h8C220004 : $urandom;
            @(negedge CLK);
            if (ram_ren) ren_n++;
            if (ihit) begin ihit_n++; hit_k = k; got = iload; end
            if (dhit) dhit_n++;
            if (k >= 1 && k <= 3) begin
                n_tests++;
                if (ram_addr !== 32'h40) begin n_fail++; $display("FAIL fetch_addr k=%0d: got %h expected 40", k, ram_addr); end
            end
            tick();
        end
        ram_ready = 0;
        n_tests++;
        if (ren_n != 3) begin n_fail++; $display("FAIL fetch_ren_cycles: got %0d expected 3", ren_n); end
        n_tests++;
        if (ihit_n != 1 || hit_k != 3) begin n_fail++; $display("FAIL fetch_ihit: count %0d at %0d expected 1 at 3", ihit_n, hit_k); end
        n_tests++;
        if (got !== 32'h8C220004) begin n_fail++; $display("FAIL fetch_iload: got %h expected 8c220004", got); end
        n_tests++;
        if (dhit_n != 0) begin n_fail++; $display("FAIL fetch_no_dhit: got %0d expected 0", dhit_n); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        ram_ready = 1; ram_load = $urandom;
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL both_k0: got %h expected 0", all_out); end
        tick();
        @(negedge CLK);
        n_tests++;
        if ({ram_wen, ram_ren, dhit, ihit} !== 4'b1010 || ram_store !== 32'hDEADBEEF || ram_addr !== 32'h100) begin
            n_fail++; $display("FAIL both_dgrant: wen/ren/dhit/ihit=%b store=%h addr=%h expected 1010 deadbeef 100",
                               {ram_wen, ram_ren, dhit, ihit}, ram_store, ram_addr);
        end
        tick();
        dWEN = 0;
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL both_gap: got %h expected 0", all_out); end
        tick();
        ram_load = 32'h0BADF00D;
        @(negedge CLK);
        n_tests++;
        if ({ram_wen, ram_ren, dhit, ihit} !== 4'b0101 || iload !== 32'h0BADF00D || ram_addr !== 32'h80 || ram_store !== 0) begin
            n_fail++; $display("FAIL both_igrant: wen/ren/dhit/ihit=%b iload=%h addr=%h expected 0101 0badf00d 80",
                               {ram_wen, ram_ren, dhit, ihit}, iload, ram_addr);
        end
        tick();
        iREN = 0;
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL both_end: got %h expected 0", all_out); end
        ram_ready = 0;
    endtask

    task automatic test_withdraw();
        do_reset();
        ram_ready = 0; dREN = 1; daddr = 32'h300; iREN = 1; iaddr = 32'h44;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        n_tests++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h300) begin n_fail++; $display("FAIL wd_grant: ren=%b addr=%h expected 1 300", ram_ren, ram_addr); end
        tick();
        dREN = 0; ram_ready = 1;
        @(negedge CLK);
        n_tests++;
        if (ram_ren !== 1'b0 || dhit !== 1'b0 || ihit !== 1'b0) begin n_fail++; $display("FAIL wd_drop: ren=%b dhit=%b ihit=%b expected 0 0 0", ram_ren, dhit, ihit); end
        tick();
        @(negedge CLK);
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL wd_idle: got %h expected 0", all_out); end
        tick();
        @(negedge CLK);
        n_tests++;
        if (ihit !== 1'b1 || ram_ren !== 1'b1 || ram_addr !== 32'h44 || dhit !== 1'b0) begin
            n_fail++; $display("FAIL wd_fetch: ihit=%b ren=%b addr=%h dhit=%b expected 1 1 44 0", ihit, ram_ren, ram_addr, dhit);
        end
        tick();
        iREN = 0; ram_ready = 0;
    endtask

    task automatic test_ready_idle();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            ram_ready = 1'($urandom); ram_load = $urandom; iaddr = $urandom; daddr = $urandom; dstore = $urandom;
            @(negedge CLK);
            n_tests++;
            if (all_out !== '0) begin n_fail++; $display("FAIL ready_idle k=%0d: got %h expected 0", k, all_out); end
            tick();
        end
        ram_ready = 0;
    endtask

    task automatic test_fairness();
        int seq[$];
        int i_n = 0, d_n = 0;
        int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
        do_reset();
        dREN = 1; iREN = 1; ram_ready = 1; daddr = 32'h500; iaddr = 32'h600;
        for (int k = 0; k < 50; k++) begin
            ram_load = $urandom;
            @(negedge CLK);
            if (ihit) begin seq.push_back(1); i_n++; end
            if (dhit) begin seq.push_back(2); d_n++; end
            tick();
        end
        dREN = 0; iREN = 0; ram_ready = 0;
        n_tests++;
        if (i_n != (FAIR ? 5 : 0) || d_n != (FAIR ? 20 : 25)) begin
            n_fail++; $display("FAIL fair_counts: ihits %0d dhits %0d expected %0d %0d", i_n, d_n, FAIR ? 5 : 0, FAIR ? 20 : 25);
        end
        if (FAIR) begin
            for (int j = 0; j < 6; j++) begin
                n_tests++;
                if (j >= seq.size() || seq[j] != exp_seq[j]) begin
                    n_fail++; $display("FAIL fair_order[%0d]: got %0d expected %0d", j, j < seq.size() ? seq[j] : 0, exp_seq[j]);
                end
            end
        end
    endtask

    task automatic test_random();
        int owner = 0, streak = 0;
        bit ip = 0, dp = 0, dw = 0;
        logic [AW-1:0] ia = 0, da = 0, e_addr;
        logic [DW-1:0] ds = 0, e_store, e_iload, e_dload;
        logic e_ihit, e_dhit, e_ren, e_wen;
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; ia = $urandom; end
            if (!dp && $urandom_range(0, 2) == 0) begin dp = 1; dw = 1'($urandom); da = $urandom; ds = $urandom; end
            iREN = ip; iaddr = ip ? ia : $urandom;
            dREN = dp && !dw; dWEN = dp && dw; daddr = da; dstore = ds;
            ram_ready = 1'($urandom); ram_load = $urandom;
            e_ihit = owner == 1 && ram_ready;
            e_dhit = owner == 2 && ram_ready;
            e_iload = e_ihit ? ram_load : 0;
            e_dload = e_dhit ? ram_load : 0;
            e_ren = owner == 1 || (owner == 2 && !dw);
            e_wen = owner == 2 && dw;
            e_addr = owner == 1 ? ia : owner == 2 ? da : 0;
            e_store = owner == 2 ? ds : 0;
            @(negedge CLK);
            n_tests++;
            if (ihit !== e_ihit) begin n_fail++; $display("FAIL rnd_ihit c%0d: got %b expected %b", k, ihit, e_ihit); end
            n_tests++;
            if (dhit !== e_dhit) begin n_fail++; $display("FAIL rnd_dhit c%0d: got %b expected %b", k, dhit, e_dhit); end
            n_tests++;
            if (iload !== e_iload) begin n_fail++; $display("FAIL rnd_iload c%0d: got %h expected %h", k, iload, e_iload); end
            n_tests++;
            if (dload !== e_dload) begin n_fail++; $display("FAIL rnd_dload c%0d: got %h expected %h", k, dload, e_dload); end
            n_tests++;
            if (ram_ren !== e_ren) begin n_fail++; $display("FAIL rnd_ren c%0d: got %b expected %b", k, ram_ren, e_ren); end
            n_tests++;
            if (ram_wen !== e_wen) begin n_fail++; $display("FAIL rnd_wen c%0d: got %b expected %b", k, ram_wen, e_wen); end
            n_tests++;
            if (ram_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h expected %h", k, ram_addr, e_addr); end
            n_tests++;
            if (ram_store !== e_store) begin n_fail++; $display("FAIL rnd_store c%0d: got %h expected %h", k, ram_store, e_store); end
            if (owner != 0) begin
                if (ram_ready) begin
                    if (owner == 1) begin ip = 0; streak = 0; end
                    else begin dp = 0; streak = streak < 15 ? streak + 1 : 15; end
                    owner = 0;
                end
            end else if (dp && !(FAIR && streak >= MAXD && ip)) owner = 2;
            else if (ip) owner = 1;
            tick();
        end
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_same_cycle();
        test_withdraw();
        test_ready_idle();
        test_fairness();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single RAM port between the instruction-fetch and data-access request streams of one core. It sits between the request/hazard unit and the memory controller. It grants one requester at a time, holds the grant until RAM completes, and returns per-requester hit pulses with load data. Data requests take priority; an optional fairness counter bounds instruction starvation.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- MAX_DSTREAK, 4, consecutive data grants allowed before a pending fetch wins (fairness build only; range 1..15)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-high
- iREN  in  1  instruction read request; held until ihit
- iaddr  in  ADDR_W  instruction address
- dREN  in  1  data read request; held until dhit
- dWEN  in  1  data write request; held until dhit; dREN and dWEN are never both high
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- ihit  out  1  instruction access complete (1-cycle pulse)
- iload  out  DATA_W  instruction word, valid when ihit
- dhit  out  1  data access complete (1-cycle pulse)
- dload  out  DATA_W  data read word, valid when dhit with dREN
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_ready  in  1  RAM access completes this cycle

## Operation
- FSM states: IDLE, IGRANT, DGRANT (registered).
- IDLE:
  - If dREN|dWEN is pending and fetch is not forced, go to DGRANT.
  - Otherwise, if iREN is pending, go to IGRANT.
  - Otherwise, stay in IDLE.
  - Fetch is forced only in the fairness build, when dstreak >= MAX_DSTREAK and iREN=1.
- IGRANT:
  - Drive ram_ren=1, ram_addr=iaddr.
  - On ram_ready: ihit=1, iload=ram_load, go to IDLE.
- DGRANT:
  - Drive ram_ren=dREN, ram_wen=dWEN, ram_addr=daddr, ram_store=dstore.
  - On ram_ready: dhit=1, dload=ram_load, go to IDLE.
- RAM outputs and hits are combinational from state and inputs.
- In IDLE: ram_ren=ram_wen=0, ram_addr=0, ram_store=0.
- iload/dload are 0 when the corresponding hit is 0.
- Request withdrawn mid-grant (granted requester's REN/WEN falls before ram_ready):
  - RAM strobes drop the same cycle.
  - No hit is issued; return to IDLE next cycle.
- ram_ready while IDLE is ignored.
- Both requests arrive in the same IDLE cycle: data wins, unless the fetch is forced (fairness build).
- Only the granted requester may see a hit; the other hit stays 0.

## Timing
- A request sampled in IDLE at edge n is granted at cycle n+1; RAM strobes are first visible in cycle n+1.
- ram_ready in cycle m gives a hit in cycle m and IDLE at m+1.
  - Minimum request-to-hit: 2 cycles (ready in the first grant cycle).
- A mandatory IDLE cycle separates consecutive grants, so back-to-back accesses occur at best every 2 cycles.
- Reset (any cycle, including mid-grant): next state IDLE, dstreak=0.
  - All outputs read 0 from the cycle after the reset edge.
  - An interrupted access produces no hit.

## Configuration
- Macro: MEMORY_ARBITER_FAIR_EN.
- Defined:
  - A 4-bit dstreak counter is compiled in.
  - It increments on each dhit, saturating at 15, and clears on each ihit.
  - When dstreak >= MAX_DSTREAK and iREN=1 in IDLE, IGRANT is chosen even if a data request is pending.
- Undefined:
  - No counter.
  - Strict data priority; a fetch waits indefinitely while data requests keep arriving.

## Test plan
- Reset mid-DGRANT with dWEN=1 and ram_ready not yet seen -> no dhit; all outputs 0 in the next cycle; FSM in IDLE.
- Lone iREN, iaddr=0x40, ram_ready 3 cycles after grant, ram_load=0x8C220004 -> single ihit cycle with iload=0x8C220004; ram_ren high for exactly 3 cycles; dhit never asserted.
- iREN and dWEN in the same cycle, daddr=0x100, dstore=0xDEADBEEF, ram_ready every grant cycle -> DGRANT first with ram_wen=1 and ram_store=0xDEADBEEF; dhit; one IDLE cycle; then IGRANT and ihit.
- dREN withdrawn 1 cycle into DGRANT -> ram_ren drops the same cycle; no dhit; IDLE next cycle; a pending iREN is granted afterward.
- Fairness build, MAX_DSTREAK=4, dREN held continuously with iREN held, ram_ready every grant -> exactly 4 dhits, then an ihit, then data resumes. Non-fairness build, same stimulus -> no ihit over 50 cycles.
- ram_ready pulsed while IDLE, no requests -> ihit=dhit=0 and RAM strobes 0 throughout.
